// File: rtl/ltl_stream_pkg.sv
// Shared types and constants for the LTL monitor symbol streamer.
package ltl_stream_pkg;

    localparam int SYM_W_DEF  = 8;
    localparam int DROP_CNT_W = 16;

    typedef logic [SYM_W_DEF-1:0] symbol_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        STREAM,
        DRAIN
    } state_e;

endpackage

// File: rtl/ltl_sym_fifo.sv
// Event buffer for the symbol streamer: synchronous FIFO with flush and a
// registered occupancy count (one extra bit separates full from empty).
module ltl_sym_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    // a pop frees the slot in the same cycle, so push-on-full is legal with pop
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (!do_push && do_pop)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/ltl_symbol_streamer.sv
// Buffers proposition vectors and streams them as symbols to Automata monitors,
// releasing monitor reset on the first symbol. Optional dedup: LTL_STREAM_DEDUP_EN.
module ltl_symbol_streamer
    import ltl_stream_pkg::*;
#(
    parameter int SYM_W      = SYM_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  ev_valid,
    input  logic [SYM_W-1:0]      ev_props,
    output logic                  ev_ready,
    output logic [SYM_W-1:0]      symbols,
    output logic                  run,
    output logic                  mon_reset,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    state_e           state, state_nx;
    logic [RCW-1:0]   rst_cnt, rst_cnt_nx;
    logic [SYM_W-1:0] sym_nx, head;
    logic             run_nx, mrst_nx;
    logic             flush, push, pop, accept, trace_start;
    logic             full, empty;
    logic [AW:0]      cnt, cnt_nx;

    assign accept      = ev_valid && ev_ready;
    assign trace_start = (state == IDLE) && start;

    ltl_sym_fifo #(.W(SYM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .din     (ev_props),
        .head    (head),
        .count   (cnt),
        .full    (full),
        .empty   (empty)
    );

`ifdef LTL_STREAM_DEDUP_EN
    logic [SYM_W-1:0] last_props;
    logic             last_vld;
    logic             dup;

    assign dup  = last_vld && (ev_props == last_props);
    assign push = accept && !dup;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_props <= '0;
            last_vld   <= 1'b0;
            drop_cnt   <= '0;
        end else if (trace_start) begin
            last_vld <= 1'b0;
            drop_cnt <= '0;
        end else if (accept) begin
            if (dup) begin
                if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end else begin
                last_props <= ev_props;
                last_vld   <= 1'b1;
            end
        end
    end
`else
    assign push     = accept;
    assign drop_cnt = '0;
`endif

    always_comb begin
        state_nx   = state;
        rst_cnt_nx = rst_cnt;
        flush      = 1'b0;
        pop        = 1'b0;
        run_nx     = 1'b0;
        sym_nx     = symbols;
        mrst_nx    = mon_reset;
        case (state)
            IDLE: begin
                mrst_nx = 1'b1;
                if (start) begin
                    state_nx   = ARM;
                    rst_cnt_nx = RCW'(RST_CYCLES);
                    flush      = 1'b1;
                end
            end
            ARM: begin
                if (rst_cnt != '0) rst_cnt_nx = rst_cnt - RCW'(1);
                // an aborted arm never releases the monitors
                if (stop) begin
                    state_nx = IDLE;
                    flush    = 1'b1;
                end else if (rst_cnt == '0 && !empty) begin
                    state_nx = STREAM;
                    mrst_nx  = 1'b0;
                    run_nx   = 1'b1;
                    sym_nx   = head;
                    pop      = 1'b1;
                end
            end
            STREAM: begin
                if (!empty) begin
                    run_nx = 1'b1;
                    sym_nx = head;
                    pop    = 1'b1;
                end
                if (stop) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!empty) begin
                    run_nx = 1'b1;
                    sym_nx = head;
                    pop    = 1'b1;
                end else begin
                    mrst_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_nx = cnt;
        if (flush)
            cnt_nx = '0;
        else if (push && !pop)
            cnt_nx = cnt + (AW+1)'(1);
        else if (!push && pop)
            cnt_nx = cnt - (AW+1)'(1);
    end

    // ready/busy are registered from next-state values so they track state and count exactly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rst_cnt   <= '0;
            symbols   <= '0;
            run       <= 1'b0;
            mon_reset <= 1'b1;
            busy      <= 1'b0;
            ev_ready  <= 1'b0;
        end else begin
            state     <= state_nx;
            rst_cnt   <= rst_cnt_nx;
            symbols   <= sym_nx;
            run       <= run_nx;
            mon_reset <= mrst_nx;
            busy      <= (state_nx != IDLE);
            ev_ready  <= ((state_nx == ARM) || (state_nx == STREAM)) && (cnt_nx != FULL_CNT);
        end
    end

endmodule

// File: doc/ltl_symbol_streamer.md
Name: ltl_symbol_streamer

Overview:
- Producer side of the monitor symbol interface: collects per-cycle atomic-proposition vectors from core trace taps and buffers them in a FIFO.
- Emits them as 8-bit symbols with run strobes to a bank of Automata_* monitors.
- Sequences the monitors' active-high reset so that start_of_data coincides exactly with the first symbol of each trace.
- Sits between the cva6 trace/commit tap logic and the monitor clusters; one instance drives all clusters of a monitor group.

Parameters:
- SYM_W, 8, symbol width; equals the monitor symbols width.
- FIFO_DEPTH, 8, entries in the event buffer; power of two, at least 2.
- RST_CYCLES, 2, minimum cycles mon_reset is held high before release; at least 1.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin a new trace (ignored unless IDLE)
- stop  in  1  pulse; end the trace after draining (ignored in IDLE/DRAIN)
- ev_valid  in  1  event handshake valid
- ev_props  in  SYM_W  proposition vector for one event
- ev_ready  out  1  event handshake ready
- symbols  out  SYM_W  symbol to monitors, registered
- run  out  1  symbol-valid strobe to monitors, registered
- mon_reset  out  1  active-high synchronous reset to monitors, registered
- busy  out  1  high in any state other than IDLE
- drop_cnt  out  16  events removed by dedup; saturating, reads 0 without the feature

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset_n). All outputs are registered.
- Reset values: symbols=0, run=0, mon_reset=1, busy=0, ev_ready=0, drop_cnt=0. FIFO is empty and the FSM is in IDLE.
- FSM states:
  - IDLE: mon_reset=1, ev_ready=0. start moves to ARM, loads rst_cnt=RST_CYCLES, and clears the FIFO.
  - ARM: mon_reset=1, ev_ready=!full, rst_cnt decrements to 0.
    - Leaves when rst_cnt==0 AND FIFO non-empty. That cycle registers mon_reset<=0, run<=1, symbols<=head, and pops. Next state is STREAM.
    - The first symbol is therefore presented in the first cycle mon_reset is low, aligned with monitor start_of_data.
  - STREAM: ev_ready=!full.
    - FIFO non-empty: pop, symbols<=head, run<=1.
    - FIFO empty: run<=0 and symbols holds its last value.
    - stop moves to DRAIN.
  - DRAIN: ev_ready=0. Pops continue as in STREAM. When the FIFO is empty, the next edge registers run<=0 and mon_reset<=1 and the FSM returns to IDLE.
- stop while in ARM: go directly to IDLE, flush the FIFO, and keep mon_reset high. A trace that emitted no symbols never releases the monitors.
- Handshake: an event is accepted on clk edge when ev_valid&&ev_ready. ev_props must be stable while ev_valid is high and ready is low.
- Latency: an event accepted into an empty FIFO in STREAM appears on symbols with run=1 on the following cycle (1-cycle latency).
- Simultaneous push and pop: allowed in every state, including when full (pop frees the slot in the same cycle; ready is computed from the registered count, so full means ready=0).
- FIFO pointers: log2(FIFO_DEPTH) bits, wrap modulo depth, plus an extra count bit to separate full from empty.
- start while busy: ignored. Simultaneous start and stop in IDLE: start wins.
- Asynchronous reset mid-trace: all state is lost immediately and outputs go to their reset values. Monitors see mon_reset=1 on the next edge.

Optional Feature:
- Macro: LTL_STREAM_DEDUP_EN
- Defined:
  - An accepted event equal to the most recently enqueued props (within the same trace) is acknowledged but not enqueued; drop_cnt increments, saturating at 16'hFFFF.
  - The first event of a trace is always enqueued.
  - drop_cnt clears on start.
  - Valid only for stutter-invariant properties.
- Undefined: every accepted event is enqueued; drop_cnt is tied to 0; no compare logic.

Decomposition:
- Package ltl_stream_pkg:
  - state enum {IDLE, ARM, STREAM, DRAIN}
  - symbol_t typedef (logic [SYM_W-1:0] with SYM_W=8)
  - DROP_CNT_W=16
- One sub-module, ltl_sym_fifo: synchronous FIFO with push, pop, flush, full, empty, head. It uses reset_n asynchronously.

Test Plan:
- Reset then start; push 8'h1F at cycle 0 of ARM with RST_CYCLES=2 -> mon_reset high for exactly 3 cycles after start, then symbols=8'h1F with run=1 in the first cycle mon_reset=0.
- In STREAM, push 8'h00, 8'h90, 8'hF5 back-to-back -> three consecutive run=1 cycles carrying those values, each 1 cycle after acceptance; then run=0 with symbols holding 8'hF5.
- Hold the FIFO full (FIFO_DEPTH=8) with ev_valid high while the monitors drain -> ev_ready=0 while count==8; no event lost or duplicated over 20 events; order preserved.
- stop with 3 entries queued -> ev_ready=0 immediately; 3 run pulses; then mon_reset=1, busy=0.
- stop during ARM with an empty FIFO -> IDLE; mon_reset never drops; run never asserted.
- With LTL_STREAM_DEDUP_EN, push 8'h10, 8'h10, 8'h10, 8'h20 -> symbols 8'h10, 8'h20 only; drop_cnt=2. Without the macro: four symbols; drop_cnt=0.
